// File: rtl/serial_add_sub.sv
// ---------------------------------------------------------------------------
// serial_add_sub
//
// Multi-cycle adder/subtractor. Each clock it processes SLICE bits, LSB first,
// through a SLICE-bit ripple slice. The carry between slices is held in a
// register, so the full carry chain is WIDTH bits long and takes
// N = WIDTH/SLICE run cycles. This block trades latency for area.
//
// Parameters
//   WIDTH  operand/result width; must be >= 2
//   SLICE  bits processed per clock; must divide WIDTH
//
// Ports
//   clk    clock; all state changes on the rising edge
//   rst    synchronous reset, active-high; takes priority over start
//   start  request an operation; only sampled in IDLE or DONE
//   sub    0: a + b + cin, 1: a - b (computed as a + ~b + 1, cin ignored)
//   a, b   operands, captured on an accepted start
//   cin    carry-in for add mode, captured on an accepted start
//   busy   high while the operation runs; start is ignored then
//   done   one-cycle pulse when sum/cout/ovf hold a new result
//   sum    result; held until the next result or reset
//   cout   carry out of the MSB (in sub mode 1 = no borrow)
//   ovf    signed overflow (carry into MSB xor carry out of MSB)
// ---------------------------------------------------------------------------
module serial_add_sub #(
  parameter int WIDTH = 8,
  parameter int SLICE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(N - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // One SLICE-bit ripple add; the top bit of the result is the slice carry-out.
  function automatic logic [SLICE:0] slice_add(
    input logic [SLICE-1:0] x,
    input logic [SLICE-1:0] y,
    input logic             c
  );
    slice_add = {1'b0, x} + {1'b0, y} + {{SLICE{1'b0}}, c};
  endfunction

  logic [1:0]       state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] acc_r;
  logic             carry_r;
  logic [CW-1:0]    count_r;

  logic [SLICE:0]   slice_s;
  logic [SLICE-1:0] slice_sum_s;
  logic             slice_cout_s;
  logic             msb_cin_s;
  logic [WIDTH-1:0] acc_next_s;

  // Current slice result and the carry into its top bit. On the last run
  // cycle the top bit of the slice is the operand MSB, so a^b^s recovers the
  // carry into the MSB without a separate partial adder.
  always_comb begin
    slice_s      = slice_add(a_r[SLICE-1:0], b_r[SLICE-1:0], carry_r);
    slice_sum_s  = slice_s[SLICE-1:0];
    slice_cout_s = slice_s[SLICE];
    msb_cin_s    = a_r[SLICE-1] ^ b_r[SLICE-1] ^ slice_sum_s[SLICE-1];
  end

  // New result slice enters at the top of the accumulator; after N cycles
  // the first (LSB) slice has reached bit 0.
  generate
    if (SLICE < WIDTH) begin : g_shift
      assign acc_next_s = {slice_sum_s, acc_r[WIDTH-1:SLICE]};
    end else begin : g_full
      assign acc_next_s = slice_sum_s;
    end
  endgenerate

  // Control FSM, operand/accumulator shifting and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      acc_r   <= '0;
      carry_r <= 1'b0;
      count_r <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            // Subtraction is a + ~b + 1: invert b here and seed the carry.
            a_r     <= a;
            b_r     <= sub ? ~b : b;
            carry_r <= sub ? 1'b1 : cin;
            acc_r   <= '0;
            count_r <= '0;
            busy    <= 1'b1;
            state_r <= RUN;
          end else begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        RUN: begin
          a_r     <= a_r >> SLICE;
          b_r     <= b_r >> SLICE;
          acc_r   <= acc_next_s;
          carry_r <= slice_cout_s;
          if (count_r == LAST_COUNT) begin
            // Outputs change only here, so partial results never show.
            count_r <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
            sum     <= acc_next_s;
            cout    <= slice_cout_s;
            ovf     <= msb_cin_s ^ slice_cout_s;
            state_r <= DONE;
          end else begin
            count_r <= count_r + CW'(1);
            busy    <= 1'b1;
            state_r <= RUN;
          end
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
